// File: rtl/mul_share_pkg.sv
// Shared types, widths and round-robin helper for the multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int unsigned MUL_A_W  = 18;
    localparam int unsigned MUL_B_W  = 18;
    localparam int unsigned MUL_P_W  = 36;

    // Tags are sized for the largest supported requester count (8) so one
    // package type serves every N_REQ; unused high id bits stay zero.
    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned TAG_ID_W = 3;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                found;
        logic [TAG_ID_W-1:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, wrapping. Callers zero-pad valid
    // above N_REQ, so wrapping mod MAX_REQ gives the same order as mod N_REQ.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                      input logic [TAG_ID_W-1:0] ptr);
        pick_t               r;
        logic [TAG_ID_W-1:0] j;
        r = '0;
        j = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            j = ptr + TAG_ID_W'(i);
            if (!r.found && valid[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester-facing bus of the multiplier-sharing arbiter.
interface mul_share_arbiter_if
    import mul_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) ();

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*MUL_A_W-1:0] req_a;
    logic [N_REQ*MUL_B_W-1:0] req_b;
    logic [N_REQ-1:0]         res_valid;
    logic [N_REQ-1:0]         res_ready;
    logic [MUL_P_W-1:0]       res_p;
    logic [31:0]              perf_busy_cnt;
    logic [31:0]              perf_stall_cnt;

    // Requester / environment side.
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p, perf_busy_cnt, perf_stall_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p, perf_busy_cnt, perf_stall_cnt
    );

endinterface

// File: rtl/top_module_mul_mul_18ns_18ns_36_4_1.sv
// HLS-style pipelined unsigned multiplier. NUM_STAGE counts the combinational
// input stage, so NUM_STAGE-1 register stages separate din capture from dout.
// Data registers carry no reset; consumers qualify dout with their own valid.
module top_module_mul_mul_18ns_18ns_36_4_1 #(
    parameter int unsigned NUM_STAGE  = 4,
    parameter int unsigned din0_WIDTH = 18,
    parameter int unsigned din1_WIDTH = 18,
    parameter int unsigned dout_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int unsigned P_STAGES = NUM_STAGE - 2;

    logic [din0_WIDTH-1:0] a_q;
    logic [din1_WIDTH-1:0] b_q;
    logic [dout_WIDTH-1:0] p_q [P_STAGES];

    // Operand capture, product, and output delay line, all frozen when ce=0.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_q    <= din0;
            b_q    <= din1;
            p_q[0] <= dout_WIDTH'(a_q) * dout_WIDTH'(b_q);
            for (int unsigned i = 1; i < P_STAGES; i++) begin
                p_q[i] <= p_q[i-1];
            end
        end
    end

    assign dout = p_q[P_STAGES-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined 18x18 multiplier among N_REQ requesters.
// A tag pipeline parallel to the multiplier routes each product back to its
// issuer; a stalled tail freezes multiplier and tags together.
// Optional: define MUL_SHARE_PERF_CNT_EN to build saturating busy/stall counters.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    mul_share_arbiter_if.slave  bus
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    tag_t               tag_q [MUL_LATENCY];
    tag_t               tag_d [MUL_LATENCY];
    tag_t               tail_c;
    logic               tail_rdy_c;
    logic               stall_c;
    logic               adv_c;
    logic               issue_c;
    pick_t              pick_c;
    logic [N_REQ-1:0]   req_ready_c;
    logic [N_REQ-1:0]   res_valid_c;
    logic [MUL_A_W-1:0] mul_a_c;
    logic [MUL_B_W-1:0] mul_b_c;
    logic [MUL_P_W-1:0] mul_p;

    assign tail_c = tag_q[MUL_LATENCY-1];

    // Stall when the tail's owner cannot take its product this cycle.
    always_comb begin
        tail_rdy_c = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (tail_c.id == TAG_ID_W'(k)) begin
                tail_rdy_c = bus.res_ready[k];
            end
        end
        stall_c = tail_c.vld & ~tail_rdy_c;
        adv_c   = ~stall_c;
    end

    // Round-robin grant, handshake and operand mux into the multiplier.
    always_comb begin
        pick_c      = rr_pick(MAX_REQ'(bus.req_valid), TAG_ID_W'(rr_ptr_q));
        issue_c     = adv_c & pick_c.found;
        req_ready_c = '0;
        mul_a_c     = bus.req_a[MUL_A_W-1:0];
        mul_b_c     = bus.req_b[MUL_B_W-1:0];
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (pick_c.idx == TAG_ID_W'(k)) begin
                mul_a_c        = bus.req_a[k*MUL_A_W +: MUL_A_W];
                mul_b_c        = bus.req_b[k*MUL_B_W +: MUL_B_W];
                req_ready_c[k] = issue_c;
            end
        end
    end

    // Next pointer and next tag pipeline contents (bubble when nothing issues).
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue_c) begin
            if ((N_REQ == 1) || (pick_c.idx == TAG_ID_W'(N_REQ - 1))) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = ID_W'(pick_c.idx + TAG_ID_W'(1));
            end
        end
        tag_d[0].vld = issue_c;
        tag_d[0].id  = issue_c ? pick_c.idx : '0;
        for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Pointer and tag registers advance in lockstep with the multiplier ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (adv_c) begin
            rr_ptr_q <= rr_ptr_d;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // One-hot result valid decoded from the tail tag.
    always_comb begin
        res_valid_c = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            res_valid_c[k] = tail_c.vld & (tail_c.id == TAG_ID_W'(k));
        end
    end

    top_module_mul_mul_18ns_18ns_36_4_1 #(
        .NUM_STAGE  (MUL_LATENCY + 1),
        .din0_WIDTH (MUL_A_W),
        .din1_WIDTH (MUL_B_W),
        .dout_WIDTH (MUL_P_W)
    ) u_mul (
        .clk  (clk),
        .ce   (adv_c),
        .din0 (mul_a_c),
        .din1 (mul_b_c),
        .dout (mul_p)
    );

    assign bus.req_ready = req_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_p     = mul_p;

`ifdef MUL_SHARE_PERF_CNT_EN
    logic [31:0] busy_cnt_q, busy_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters.
    always_comb begin
        busy_cnt_d  = busy_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (issue_c && (busy_cnt_q != '1)) begin
            busy_cnt_d = busy_cnt_q + 32'd1;
        end
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_cnt_q  <= busy_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.perf_busy_cnt  = busy_cnt_q;
    assign bus.perf_stall_cnt = stall_cnt_q;
`else
    assign bus.perf_busy_cnt  = '0;
    assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined 18x18 unsigned multiplier (top_module_mul_mul_18ns_18ns_36_4_1) among N_REQ requesters.
- Round-robin arbitration picks one operand pair per cycle and drives the multiplier's ce.
- A tag shift register tracks which requester owns each in-flight product, so each result returns to its requester.
- Sits between HLS-generated compute units and the shared multiplier.

Parameters:
- N_REQ, 4, number of requesters (1..8).
- ID_W, 2, requester index width; equals max(1, clog2(N_REQ)).
- MUL_LATENCY, 3, register stages of the multiplier instance (edge of operand capture to p valid). Must match the instance.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  operand pair valid, per requester
- req_ready  out  N_REQ  operand pair accepted, per requester
- req_a  in  N_REQ*18  packed operand A; requester k occupies bits [18k+17:18k]
- req_b  in  N_REQ*18  packed operand B, same packing as req_a
- res_valid  out  N_REQ  product valid, per requester
- res_ready  in  N_REQ  product consumed, per requester
- res_p  out  36  product, shared by all requesters; qualified by res_valid
- perf_busy_cnt  out  32  cycles with an issue (0 without the option)
- perf_stall_cnt  out  32  stall cycles (0 without the option)

Behaviour:
- Tag pipeline: MUL_LATENCY entries {vld, id}; entry 0 is the issue side, entry MUL_LATENCY-1 is the tail.
- stall = tail.vld & ~res_ready[tail.id]. adv = ~stall.
- The multiplier's ce is driven by adv. The tag pipeline shifts only when adv=1.
- Grant:
  - Combinational search starting at rr_ptr; the first k with req_valid[k] wins.
  - req_ready[g] = adv & any valid. All other req_ready bits are 0.
  - req_ready may depend on req_valid. A requester must not make req_valid depend on req_ready.
- Handshake at a clock edge with adv=1:
  - din0/din1 take the granted operands.
  - Entry 0 is written {1, g}.
  - rr_ptr <= (g+1) mod N_REQ, wrapping from N_REQ-1 to 0.
  - With no valid request, entry 0 is written {0, x} (a bubble) and rr_ptr holds.
- Output:
  - res_valid[k] = tail.vld & (tail.id == k). At most one bit is set.
  - res_p = multiplier dout.
  - Throughput is 1 product per cycle when all consumers are ready.
- Latency: request handshake to res_valid is exactly MUL_LATENCY cycles with no stall. Each stall cycle adds 1.
- Stall:
  - The whole pipeline freezes, so multiplier registers and tags hold.
  - res_valid and res_p stay stable until res_ready.
  - No new grants are made.
  - A simultaneous res_ready on the stalling tail clears the stall in that same cycle, so issue proceeds that cycle.
- Ordering: results per requester return in issue order. Results across requesters return in global issue order.
- Arithmetic: unsigned, full 36-bit product, no truncation. 0x3FFFF*0x3FFFF = 0xFFFF80001.
- Reset (async, any time):
  - All tag vld = 0 and rr_ptr = 0, so res_valid = 0 immediately.
  - req_ready follows the comb grant, so it is 0 once the request inputs are idle.
  - Perf counters = 0.
  - In-flight products are discarded. Multiplier data registers have no reset; their garbage is masked by tag vld=0.
- N_REQ=1: rr_ptr is constant 0. The grant is req_valid[0] & adv.

Optional Feature:
- Macro MUL_SHARE_PERF_CNT_EN.
- When defined:
  - perf_busy_cnt increments on each handshake edge.
  - perf_stall_cnt increments each cycle stall=1.
  - Both counters are 32-bit and saturate at 0xFFFFFFFF; they do not wrap.
- When not defined: both outputs are tied to 0 and no counter flops are built. Ports are always present.

Decomposition:
- Package mul_share_pkg holds:
  - localparams MUL_A_W=18, MUL_B_W=18, MUL_P_W=36
  - typedef tag_t {logic vld; logic [ID_W-1:0] id;}
  - function rr_pick(valid, ptr) returning the grant index plus a found flag
- Sub-module: the existing top_module_mul_mul_18ns_18ns_36_4_1, instantiated once with din widths 18/18 and dout width 36.
- Arbiter, tag pipeline and counters stay in this module.

Test Plan:
- Single request: req0 a=3, b=5 at cycle 0, res_ready all 1 -> res_valid[0]=1 exactly at cycle 3 with res_p=15; no other res_valid bit set.
- Round-robin: all 4 req_valid held high, 8 cycles -> grants 0,1,2,3,0,1,2,3; products return with matching ids from cycle 3 onward, one per cycle.
- Backpressure: req1 issues 7*9, res_ready[1]=0 for 5 cycles -> res_valid[1] holds with res_p=63; no grants during the stall; on res_ready[1]=1 the pipeline resumes and the next product follows 1 cycle later.
- Max operands: a=b=0x3FFFF -> res_p=0xFFFF80001.
- Reset mid-operation: 2 products in flight, assert reset for 1 cycle -> res_valid=0 immediately; no stale result appears afterwards; first grant after reset goes to req0 (rr_ptr=0).
- With MUL_SHARE_PERF_CNT_EN: 6 issues plus 4 stall cycles -> perf_busy_cnt=6, perf_stall_cnt=4. Without the macro both read 0.
